// File: rtl/instr_fetcher_pkg.sv
// Shared definitions for the instruction fetcher.
//   fetch_state_t  : FSM encodings FETCH / MISS / FILL (2 bits)
//   INSTR_BYTES    : size of one instruction word in bytes
//   PC_ALIGN_MASK  : clears the byte-offset bits of a word address
//   pc_increment() : next sequential PC, wrapping modulo 2^32
package instr_fetcher_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        MISS  = 2'd1,
        FILL  = 2'd2
    } fetch_state_t;

    localparam int          INSTR_BYTES   = 4;
    localparam logic [31:0] PC_ALIGN_MASK = 32'hFFFF_FFFC;

    function automatic logic [31:0] pc_increment(input logic [31:0] pc);
        return pc + 32'(INSTR_BYTES);
    endfunction

endpackage

// File: rtl/instr_fetcher.sv
// Instruction fetch front end between the decoder and a direct-mapped I-cache.
// Looks up the current PC every cycle the output slot can accept a word, passes
// hits to the decoder, and services misses by reading memory and filling the cache
// before retrying the lookup. Back-end redirects flush the slot and restart at a new PC.
//
// Optional feature macro: IFETCH_STATS_EN adds saturating hit/miss counters.
//
// Ports:
//   clk_in, rst_in (async, active-low), rdy_in (global enable / freeze)
//   redirect_en, redirect_pc        : back-end PC redirect
//   icache_req_en/_addr, icache_hit/_instr        : cache lookup
//   icache_fill_en/_addr/_instr     : one-cycle cache write strobe
//   mem_req, mem_addr, mem_done, mem_data         : memory word read
//   out_valid, out_ready, out_instr, out_pc       : decoder handshake
//   hit_cnt, miss_cnt               : lookup statistics (IFETCH_STATS_EN only)
module instr_fetcher
    import instr_fetcher_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0
`ifdef IFETCH_STATS_EN
    , parameter int STATS_WIDTH = 32
`endif
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        redirect_en,
    input  logic [31:0] redirect_pc,
    output logic        icache_req_en,
    output logic [31:0] icache_req_addr,
    input  logic        icache_hit,
    input  logic [31:0] icache_instr,
    output logic        icache_fill_en,
    output logic [31:0] icache_fill_addr,
    output logic [31:0] icache_fill_instr,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_done,
    input  logic [31:0] mem_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc
`ifdef IFETCH_STATS_EN
    , output logic [STATS_WIDTH-1:0] hit_cnt
    , output logic [STATS_WIDTH-1:0] miss_cnt
`endif
);

    fetch_state_t state, state_d;
    logic [31:0]  pc, pc_d;
    logic         out_valid_d;
    logic [31:0]  out_instr_d, out_pc_d;
    logic         mem_req_d;
    logic [31:0]  mem_addr_d;
    logic         fill_en_d;
    logic [31:0]  fill_addr_d, fill_instr_d;
    logic         slot_free;

    // The slot can take a new word when it is empty or is being drained this cycle.
    // A redirect suppresses the lookup so nothing from the old path is issued.
    assign slot_free       = !out_valid || out_ready;
    assign icache_req_en   = rdy_in && (state == FETCH) && slot_free && !redirect_en;
    assign icache_req_addr = pc;

    // Next-state and next-value logic. mem_addr doubles as the miss address: it is
    // captured on the miss and stays stable until the fill is issued.
    // A redirect during MISS or FILL only retargets pc; the outstanding read and the
    // fill still complete because their data is valid for the missed address, and
    // FETCH then resumes from the new pc, so no separate discard flag is needed.
    always_comb begin
        state_d      = state;
        pc_d         = pc;
        out_valid_d  = out_valid;
        out_instr_d  = out_instr;
        out_pc_d     = out_pc;
        mem_req_d    = mem_req;
        mem_addr_d   = mem_addr;
        fill_en_d    = 1'b0;
        fill_addr_d  = icache_fill_addr;
        fill_instr_d = icache_fill_instr;

        if (out_valid && out_ready) begin
            out_valid_d = 1'b0;
        end

        case (state)
            FETCH: begin
                if (icache_req_en) begin
                    if (icache_hit) begin
                        out_valid_d = 1'b1;
                        out_instr_d = icache_instr;
                        out_pc_d    = pc;
                        pc_d        = pc_increment(pc);
                    end else begin
                        mem_req_d  = 1'b1;
                        mem_addr_d = pc;
                        state_d    = MISS;
                    end
                end
            end
            MISS: begin
                if (mem_done) begin
                    fill_addr_d  = mem_addr;
                    fill_instr_d = mem_data;
                    fill_en_d    = 1'b1;
                    mem_req_d    = 1'b0;
                    state_d      = FILL;
                end
            end
            FILL: begin
                state_d = FETCH;
            end
            default: begin
                state_d = FETCH;
            end
        endcase

        if (redirect_en) begin
            pc_d        = redirect_pc & PC_ALIGN_MASK;
            out_valid_d = 1'b0;
        end
    end

    // State register; rdy_in low freezes everything, including redirect handling.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state             <= FETCH;
            pc                <= RESET_PC;
            out_valid         <= 1'b0;
            out_instr         <= 32'h0;
            out_pc            <= 32'h0;
            mem_req           <= 1'b0;
            mem_addr          <= 32'h0;
            icache_fill_en    <= 1'b0;
            icache_fill_addr  <= 32'h0;
            icache_fill_instr <= 32'h0;
        end else if (rdy_in) begin
            state             <= state_d;
            pc                <= pc_d;
            out_valid         <= out_valid_d;
            out_instr         <= out_instr_d;
            out_pc            <= out_pc_d;
            mem_req           <= mem_req_d;
            mem_addr          <= mem_addr_d;
            icache_fill_en    <= fill_en_d;
            icache_fill_addr  <= fill_addr_d;
            icache_fill_instr <= fill_instr_d;
        end
    end

`ifdef IFETCH_STATS_EN
    // Every issued lookup counts as exactly one hit or one miss; both stick at all-ones.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (icache_req_en) begin
            if (icache_hit) begin
                if (hit_cnt != '1) begin
                    hit_cnt <= hit_cnt + 1'b1;
                end
            end else begin
                if (miss_cnt != '1) begin
                    miss_cnt <= miss_cnt + 1'b1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetcher.sv
// Directed testbench for instr_fetcher with a behavioural direct-mapped cache
// (64 lines, tag = addr[31:8]) and a fixed-latency memory that returns addr+0x13.
// Build with IFETCH_STATS_EN defined to also exercise the hit/miss counters.
module tb_instr_fetcher;

    localparam int MEM_LAT = 2;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b0;
    logic        rdy_in = 1'b1;
    logic        redirect_en = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        icache_req_en;
    logic [31:0] icache_req_addr;
    logic        icache_hit;
    logic [31:0] icache_instr;
    logic        icache_fill_en;
    logic [31:0] icache_fill_addr;
    logic [31:0] icache_fill_instr;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_done = 1'b0;
    logic [31:0] mem_data = 32'h0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
`ifdef IFETCH_STATS_EN
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;
`endif

    int total = 0;
    int bad   = 0;
    int mem_cnt = 0;

    logic        c_valid [64];
    logic [23:0] c_tag   [64];
    logic [31:0] c_data  [64];

    instr_fetcher #(.RESET_PC(32'h0)) dut (
        .clk_in            (clk_in),
        .rst_in            (rst_in),
        .rdy_in            (rdy_in),
        .redirect_en       (redirect_en),
        .redirect_pc       (redirect_pc),
        .icache_req_en     (icache_req_en),
        .icache_req_addr   (icache_req_addr),
        .icache_hit        (icache_hit),
        .icache_instr      (icache_instr),
        .icache_fill_en    (icache_fill_en),
        .icache_fill_addr  (icache_fill_addr),
        .icache_fill_instr (icache_fill_instr),
        .mem_req           (mem_req),
        .mem_addr          (mem_addr),
        .mem_done          (mem_done),
        .mem_data          (mem_data),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_instr         (out_instr),
        .out_pc            (out_pc)
`ifdef IFETCH_STATS_EN
        , .hit_cnt         (hit_cnt)
        , .miss_cnt        (miss_cnt)
`endif
    );

    always #5 clk_in = ~clk_in;

    // Combinational cache lookup model.
    assign icache_hit   = c_valid[icache_req_addr[7:2]] &&
                          (c_tag[icache_req_addr[7:2]] == icache_req_addr[31:8]);
    assign icache_instr = c_data[icache_req_addr[7:2]];

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cachePut(input logic [31:0] a, input logic [31:0] d);
        c_valid[a[7:2]] = 1'b1;
        c_tag[a[7:2]]   = a[31:8];
        c_data[a[7:2]]  = d;
    endtask

    task automatic applyStimulus(input logic rdy, input logic redir, input logic [31:0] rpc,
                                 input logic ready);
        rdy_in      = rdy;
        redirect_en = redir;
        redirect_pc = rpc;
        out_ready   = ready;
    endtask

    // Holds reset asserted with an empty cache; the caller preloads and releases it.
    task automatic doReset();
        rst_in = 1'b0;
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 64; i++) begin
            c_valid[i] = 1'b0;
            c_tag[i]   = 24'h0;
            c_data[i]  = 32'h0;
        end
        repeat (2) @(negedge clk_in);
    endtask

    // Memory responder and cache fill port, updated just after each rising edge.
    initial begin
        forever begin
            @(posedge clk_in);
            #1;
            if (icache_fill_en) begin
                cachePut(icache_fill_addr, icache_fill_instr);
            end
            if (!rst_in) begin
                mem_done = 1'b0;
                mem_cnt  = 0;
            end else if (mem_done) begin
                mem_done = 1'b0;
                mem_cnt  = 0;
            end else if (mem_req && rdy_in) begin
                mem_cnt++;
                if (mem_cnt == MEM_LAT) begin
                    mem_done = 1'b1;
                    mem_data = mem_addr + 32'h13;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic seen_valid;

        // Cold start from an empty cache
        doReset();
        checkOutput("rst_out_valid", out_valid, 1'b0);
        checkOutput("rst_mem_req", mem_req, 1'b0);
        checkOutput("rst_fill_en", icache_fill_en, 1'b0);
        checkOutput("rst_out_pc", out_pc, 32'h0);
        checkOutput("rst_out_instr", out_instr, 32'h0);
        checkOutput("rst_pc", icache_req_addr, 32'h0);
        checkOutput("rst_mem_addr", mem_addr, 32'h0);
        rst_in = 1'b1;
        for (int n = 0; n < 40 && !mem_req; n++) @(negedge clk_in);
        checkOutput("t1_mem_req", mem_req, 1'b1);
        checkOutput("t1_mem_addr", mem_addr, 32'h0);
        for (int n = 0; n < 40 && !icache_fill_en; n++) @(negedge clk_in);
        checkOutput("t1_fill_en", icache_fill_en, 1'b1);
        checkOutput("t1_fill_addr", icache_fill_addr, 32'h0);
        checkOutput("t1_fill_instr", icache_fill_instr, 32'h13);
        @(negedge clk_in);
        checkOutput("t1_fill_pulse", icache_fill_en, 1'b0);
        checkOutput("t1_retry_en", icache_req_en, 1'b1);
        checkOutput("t1_retry_hit", icache_hit, 1'b1);
        @(negedge clk_in);
        checkOutput("t1_out_valid", out_valid, 1'b1);
        checkOutput("t1_out_pc", out_pc, 32'h0);
        checkOutput("t1_out_instr", out_instr, 32'h13);

        // Warm hits then backpressure on the 0x10 word
        doReset();
        for (int a = 0; a <= 16; a += 4) cachePut(32'(a), 32'h1000_0000 + 32'(a));
        rst_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_in);
            checkOutput("t2_valid", out_valid, 1'b1);
            checkOutput("t2_out_pc", out_pc, 32'(i * 4));
            checkOutput("t2_out_instr", out_instr, 32'h1000_0000 + 32'(i * 4));
            checkOutput("t2_no_mem_req", mem_req, 1'b0);
        end
        @(negedge clk_in);
        checkOutput("t3_first_pc", out_pc, 32'h10);
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            checkOutput("t3_held_valid", out_valid, 1'b1);
            checkOutput("t3_held_pc", out_pc, 32'h10);
            checkOutput("t3_held_instr", out_instr, 32'h1000_0010);
            checkOutput("t3_req_en_low", icache_req_en, 1'b0);
            checkOutput("t3_pc_next", icache_req_addr, 32'h14);
            @(negedge clk_in);
        end
        out_ready = 1'b1;

        // Redirect while a miss is outstanding
        doReset();
        cachePut(32'h100, 32'hDEAD_0100);
        rst_in = 1'b1;
        applyStimulus(1'b1, 1'b1, 32'h40, 1'b1);
        @(negedge clk_in);
        redirect_en = 1'b0;
        for (int n = 0; n < 40 && !mem_req; n++) @(negedge clk_in);
        checkOutput("t4_mem_req", mem_req, 1'b1);
        checkOutput("t4_mem_addr", mem_addr, 32'h40);
        applyStimulus(1'b1, 1'b1, 32'h103, 1'b1);
        @(negedge clk_in);
        redirect_en = 1'b0;
        checkOutput("t4_req_kept", mem_req, 1'b1);
        checkOutput("t4_addr_kept", mem_addr, 32'h40);
        seen_valid = 1'b0;
        for (int n = 0; n < 40 && !icache_fill_en; n++) begin
            @(negedge clk_in);
            if (out_valid) seen_valid = 1'b1;
        end
        checkOutput("t4_fill_addr", icache_fill_addr, 32'h40);
        checkOutput("t4_fill_instr", icache_fill_instr, 32'h53);
        checkOutput("t4_no_out_0x40", seen_valid, 1'b0);
        for (int n = 0; n < 40 && !out_valid; n++) @(negedge clk_in);
        checkOutput("t4_out_pc", out_pc, 32'h100);
        checkOutput("t4_out_instr", out_instr, 32'hDEAD_0100);

        // Redirect coincident with a hit, PC wrap, and freeze
        doReset();
        cachePut(32'h0, 32'hA000_0000);
        cachePut(32'h4, 32'hA000_0004);
        cachePut(32'h220, 32'hA000_0220);
        cachePut(32'hFFFF_FFFC, 32'hA000_FFFC);
        rst_in = 1'b1;
        applyStimulus(1'b1, 1'b1, 32'h221, 1'b1);
        #1;
        checkOutput("t5_no_issue", icache_req_en, 1'b0);
        @(negedge clk_in);
        redirect_en = 1'b0;
        #1;
        checkOutput("t5_flushed", out_valid, 1'b0);
        checkOutput("t5_target", icache_req_addr, 32'h220);
        checkOutput("t5_target_en", icache_req_en, 1'b1);
        @(negedge clk_in);
        checkOutput("t5_out_pc", out_pc, 32'h220);
        checkOutput("t5_out_valid", out_valid, 1'b1);
        applyStimulus(1'b1, 1'b1, 32'hFFFF_FFFE, 1'b1);
        @(negedge clk_in);
        redirect_en = 1'b0;
        #1;
        checkOutput("t5_flush2", out_valid, 1'b0);
        checkOutput("t5_top_addr", icache_req_addr, 32'hFFFF_FFFC);
        @(negedge clk_in);
        checkOutput("t5_top_pc", out_pc, 32'hFFFF_FFFC);
        checkOutput("t5_top_instr", out_instr, 32'hA000_FFFC);
        checkOutput("t5_wrap_addr", icache_req_addr, 32'h0);
        @(negedge clk_in);
        checkOutput("t5_wrap_pc", out_pc, 32'h0);
        checkOutput("t5_wrap_instr", out_instr, 32'hA000_0000);
        applyStimulus(1'b0, 1'b1, 32'h300, 1'b1);
        #1;
        checkOutput("t5_frz_req_en", icache_req_en, 1'b0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk_in);
            checkOutput("t5_frz_valid", out_valid, 1'b1);
            checkOutput("t5_frz_out_pc", out_pc, 32'h0);
            checkOutput("t5_frz_pc", icache_req_addr, 32'h4);
        end
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
        @(negedge clk_in);
        checkOutput("t5_resume_pc", out_pc, 32'h4);

        // Reset asserted while a miss is outstanding
        doReset();
        rst_in = 1'b1;
        for (int n = 0; n < 40 && !mem_req; n++) @(negedge clk_in);
        checkOutput("t7_mem_req_up", mem_req, 1'b1);
        rst_in = 1'b0;
        #1;
        checkOutput("t7_mem_req_drop", mem_req, 1'b0);
        checkOutput("t7_pc_reset", icache_req_addr, 32'h0);

`ifdef IFETCH_STATS_EN
        // Hit/miss counters and freeze
        doReset();
        checkOutput("t6_rst_hits", hit_cnt, 32'h0);
        checkOutput("t6_rst_miss", miss_cnt, 32'h0);
        cachePut(32'h0, 32'hB000_0000);
        cachePut(32'h4, 32'hB000_0004);
        cachePut(32'h8, 32'hB000_0008);
        rst_in = 1'b1;
        for (int n = 0; n < 40 && !mem_req; n++) @(negedge clk_in);
        checkOutput("t6_miss_addr", mem_addr, 32'hC);
        checkOutput("t6_hit_cnt", hit_cnt, 32'd3);
        checkOutput("t6_miss_cnt", miss_cnt, 32'd1);
        rdy_in = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk_in);
            checkOutput("t6_frz_hits", hit_cnt, 32'd3);
            checkOutput("t6_frz_miss", miss_cnt, 32'd1);
            checkOutput("t6_frz_pc", icache_req_addr, 32'hC);
        end
        rdy_in = 1'b1;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
